// File: rtl/legv8_pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard control slice.
package legv8_pipe_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    // X31 reads as zero, so a write to it can never feed a later read.
    localparam reg_idx_t XZR = 5'd31;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MEMWAIT = 2'd2
    } pipe_state_t;

    function automatic logic branch_taken(input logic branch, input logic uncbranch,
                                          input logic zero);
        return uncbranch | (branch & zero);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the reads in ID.
module pipe_hazard_detect
    import legv8_pipe_pkg::*;
(
    input  logic     idex_memread,
    input  reg_idx_t idex_rd,
    input  reg_idx_t id_rn,
    input  reg_idx_t id_rm,
    input  logic     id_uses_rm,
    output logic     luh
);

    assign luh = idex_memread && (idex_rd != XZR) &&
                 ((idex_rd == id_rn) || (id_uses_rm && (idex_rd == id_rm)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the LEGv8 pipeline registers.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import legv8_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_branch,
    input  logic             exmem_uncbranch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

    pipe_state_t   state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          err_q;
    logic          luh, taken, memop, mw, tout;
    logic          inc_stall, inc_flush, inc_wait;

    pipe_hazard_detect u_detect (
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rm   (id_uses_rm),
        .luh          (luh)
    );

    assign taken = branch_taken(exmem_branch, exmem_uncbranch, exmem_zero);
    assign memop = exmem_memread | exmem_memwrite;
    // Once waiting, EX/MEM is frozen, so only dmem_ready decides whether the wait continues.
    assign mw    = (state == MEMWAIT) ? !dmem_ready : (memop && !dmem_ready);
    assign tout  = mw && (tcnt_nx >= TMO);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
            err_q <= err_q | tout;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_nx    = state;
        tcnt_nx     = tcnt;
        pc_write    = 1'b1;
        pc_src      = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        inc_wait    = 1'b0;
        if (reset) begin
            state_nx    = RUN;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (mw) begin
            state_nx    = MEMWAIT;
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            inc_wait    = 1'b1;
            if (state != MEMWAIT)
                tcnt_nx = TW'(1);
            else if (tcnt < TMO)
                tcnt_nx = tcnt + 1'b1;
        end else begin
            // Leaving MEMWAIT behaves as a full RUN cycle, including a new load-use stall.
            state_nx = RUN;
            if (taken) begin
                pc_src      = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
                inc_flush   = 1'b1;
            end else if (luh && state != STALL) begin
                state_nx    = STALL;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                inc_stall   = 1'b1;
            end
        end
    end

    assign mem_error = err_q & ~reset;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, wait_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            // Saturate at all-ones rather than wrapping.
            if (inc_stall && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (inc_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
            if (inc_wait  && wait_q  != '1) wait_q  <= wait_q  + 1'b1;
        end
    end

    assign stall_cnt = reset ? '0 : stall_q;
    assign flush_cnt = reset ? '0 : flush_q;
    assign wait_cnt  = reset ? '0 : wait_q;
`else
    logic unused_perf;
    assign unused_perf = inc_stall ^ inc_flush ^ inc_wait;
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign wait_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// stimulus against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_rn, id_rm, idex_rd;
    logic             id_uses_rm, idex_memread;
    logic             exmem_branch, exmem_uncbranch, exmem_zero;
    logic             exmem_memread, exmem_memwrite, dmem_ready;
    logic             pc_write, pc_src, ifid_write, ifid_flush;
    logic             idex_bubble, exmem_flush, pipe_freeze, mem_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: "waiting on memory", "previous cycle was a stall bubble".
    bit m_wait, m_stall, m_err;
    int m_tcnt, m_sc, m_fc, m_wc;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .exmem_branch(exmem_branch), .exmem_uncbranch(exmem_uncbranch),
        .exmem_zero(exmem_zero), .exmem_memread(exmem_memread),
        .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .pipe_freeze(pipe_freeze), .mem_error(mem_error),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clock = ~clock;

    // {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze, mem_error}
    logic [7:0] outs;
    assign outs = {pc_write, pc_src, ifid_write, ifid_flush,
                   idex_bubble, exmem_flush, pipe_freeze, mem_error};

    localparam logic [7:0] O_RESET  = 8'b0001_1100;
    localparam logic [7:0] O_NORMAL = 8'b1010_0000;
    localparam logic [7:0] O_FLUSH  = 8'b1111_1100;
    localparam logic [7:0] O_STALL  = 8'b0000_1000;
    localparam logic [7:0] O_FREEZE = 8'b0000_0010;

    function automatic int exp_cnt(input int v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic bit m_taken();
        return exmem_uncbranch || (exmem_branch && exmem_zero);
    endfunction

    function automatic bit m_luh();
        return idex_memread && idex_rd != 5'd31 &&
               (idex_rd == id_rn || (id_uses_rm && idex_rd == id_rm));
    endfunction

    function automatic bit m_memwait();
        if (m_wait) return !dmem_ready;
        return (exmem_memread || exmem_memwrite) && !dmem_ready;
    endfunction

    function automatic logic [7:0] model_outs();
        logic [7:0] e;
        if (reset)                   e = O_RESET;
        else if (m_memwait())        e = O_FREEZE;
        else if (m_taken())          e = O_FLUSH;
        else if (m_luh() && !m_stall) e = O_STALL;
        else                         e = O_NORMAL;
        if (!reset) e[0] = m_err;
        return e;
    endfunction

    // Advance the model to match the coming clock edge, then move to the next negedge.
    task automatic tick();
        if (reset) begin
            m_wait = 0; m_stall = 0; m_err = 0;
            m_tcnt = 0; m_sc = 0; m_fc = 0; m_wc = 0;
        end else if (m_memwait()) begin
            m_wc++;
            m_tcnt = m_wait ? ((m_tcnt < MEM_TIMEOUT) ? m_tcnt + 1 : m_tcnt) : 1;
            if (m_tcnt >= MEM_TIMEOUT) m_err = 1;
            m_wait = 1;
            m_stall = 0;
        end else begin
            m_wait = 0;
            if (m_taken()) begin
                m_fc++;
                m_stall = 0;
            end else if (m_luh() && !m_stall) begin
                m_sc++;
                m_stall = 1;
            end else begin
                m_stall = 0;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_idle();
        id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
        idex_memread = 1'b0; idex_rd = 5'd0;
        exmem_branch = 1'b0; exmem_uncbranch = 1'b0; exmem_zero = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== O_RESET) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %b want %b", i, outs, O_RESET);
            end
            checks++;
            if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_cnts: got %0d/%0d/%0d want 0/0/0",
                         stall_cnt, flush_cnt, wait_cnt);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd1; id_rn = 5'd1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL load_use_stall: got %b want %b", outs, O_STALL);
        end
        tick();
        idex_memread = 1'b0; exmem_memread = 1'b1;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            errors++;
            $display("FAIL load_use_after: got %b want %b", outs, O_NORMAL);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (stall_cnt !== CNT_W'(exp_cnt(1))) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_xzr();
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd31; id_rn = 5'd31; id_rm = 5'd31; id_uses_rm = 1'b1;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            errors++;
            $display("FAIL xzr_no_stall: got %b want %b", outs, O_NORMAL);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        exmem_branch = 1'b1; exmem_zero = 1'b1;
        #1;
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL branch_taken: got %b want %b", outs, O_FLUSH);
        end
        tick();
        exmem_zero = 1'b0;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            errors++;
            $display("FAIL branch_not_taken: got %b want %b", outs, O_NORMAL);
        end
        checks++;
        if (flush_cnt !== CNT_W'(exp_cnt(1))) begin
            errors++;
            $display("FAIL branch_cnt: got %0d want %0d", flush_cnt, exp_cnt(1));
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (flush_cnt !== CNT_W'(exp_cnt(1))) begin
            errors++;
            $display("FAIL branch_cnt_hold: got %0d want %0d", flush_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_memwait();
        do_reset();
        exmem_memwrite = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== O_FREEZE) begin
                errors++;
                $display("FAIL memwait_freeze cycle %0d: got %b want %b", i, outs, O_FREEZE);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            errors++;
            $display("FAIL memwait_release: got %b want %b", outs, O_NORMAL);
        end
        tick();
        set_idle();
        #1;
        checks++;
        if (wait_cnt !== CNT_W'(exp_cnt(3))) begin
            errors++;
            $display("FAIL memwait_cnt: got %0d want %0d", wait_cnt, exp_cnt(3));
        end
    endtask

    task automatic test_luh_and_taken();
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd4; id_rm = 5'd4; id_uses_rm = 1'b1;
        exmem_uncbranch = 1'b1;
        #1;
        checks++;
        if (outs !== O_FLUSH) begin
            errors++;
            $display("FAIL luh_taken_flush: got %b want %b", outs, O_FLUSH);
        end
        tick();
        // Still in RUN, so a hazard seen now must stall.
        exmem_uncbranch = 1'b0;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL luh_taken_no_stall_state: got %b want %b", outs, O_STALL);
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL luh_taken_cnt: got %0d want 0", stall_cnt);
        end
        tick();
        set_idle();
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        do_reset();
        exmem_memread = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) begin
            e = (i >= MEM_TIMEOUT) ? (O_FREEZE | 8'b1) : O_FREEZE;
            #1;
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %b want %b", i, outs, e);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_RESET) begin
            errors++;
            $display("FAIL timeout_reset: got %b want %b", outs, O_RESET);
        end
        tick();
        reset = 1'b0;
        set_idle();
        #1;
        checks++;
        if (outs !== O_NORMAL) begin
            errors++;
            $display("FAIL timeout_after_reset: got %b want %b", outs, O_NORMAL);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] pick [5];
        logic [7:0] e;
        pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2; pick[3] = 5'd3; pick[4] = 5'd31;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 59) == 0);
            id_rn           = pick[$urandom_range(0, 4)];
            id_rm           = pick[$urandom_range(0, 4)];
            idex_rd         = pick[$urandom_range(0, 4)];
            id_uses_rm      = 1'($urandom_range(0, 1));
            idex_memread    = ($urandom_range(0, 2) == 0);
            exmem_branch    = ($urandom_range(0, 3) == 0);
            exmem_uncbranch = ($urandom_range(0, 7) == 0);
            exmem_zero      = 1'($urandom_range(0, 1));
            exmem_memread   = ($urandom_range(0, 3) == 0);
            exmem_memwrite  = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 9) < 6);
            #1;
            e = model_outs();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL random_outs cycle %0d: got %b want %b", i, outs, e);
            end
            checks++;
            if (stall_cnt !== CNT_W'(reset ? 0 : exp_cnt(m_sc)) ||
                flush_cnt !== CNT_W'(reset ? 0 : exp_cnt(m_fc)) ||
                wait_cnt  !== CNT_W'(reset ? 0 : exp_cnt(m_wc))) begin
                errors++;
                $display("FAIL random_cnts cycle %0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         stall_cnt, flush_cnt, wait_cnt,
                         reset ? 0 : exp_cnt(m_sc), reset ? 0 : exp_cnt(m_fc),
                         reset ? 0 : exp_cnt(m_wc));
            end
            tick();
        end
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_load_use();
        test_xzr();
        test_branch();
        test_memwait();
        test_luh_and_taken();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
